// File: rtl/ctrl_desp_32.sv
// Transmit sequencer for a 32-bit universal shift register: load one word, shift it out N times, rebuild it from the serial return.
// Latency: handshake at edge t -> LOAD t..t+1, SHIFT t+1..t+N+1, DONE t+N+1..t+N+2, READY again at t+N+2.
// Backpressure: READY is high only in IDLE; VALID is ignored while a word is in flight.
//
// Ports:
//   CLK, RESET           clock and synchronous active-high reset
//   VALID/READY          word handshake; DATA and DIR_REQ are captured on it
//   FILL                 serial fill bit forwarded to S_IN while shifting
//   SER_IN               serial output of the downstream register
//   ENB/DIR/MODO/D/S_IN  downstream register controls and data
//   BUSY/DONE            in-flight indication and one-cycle completion pulse
//   BIT_CNT/RX_WORD      shifts completed and the word rebuilt from SER_IN
module ctrl_desp_32 #(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          VALID,
  input  logic [N-1:0]  DATA,
  input  logic          DIR_REQ,
  input  logic          FILL,
  input  logic          SER_IN,
  output logic          READY,
  output logic          ENB,
  output logic          DIR,
  output logic [1:0]    MODO,
  output logic [N-1:0]  D,
  output logic          S_IN,
  output logic          BUSY,
  output logic          DONE,
  output logic [CW-1:0] BIT_CNT,
  output logic [N-1:0]  RX_WORD
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  localparam logic [1:0]    MODE_SHIFT = 2'b00;
  localparam logic [1:0]    MODE_LOAD  = 2'b10;
  localparam logic [CW-1:0] LAST_BIT   = CW'(N - 1);

  state_t        state;
  state_t        state_nxt;
  logic [N-1:0]  hold;
  logic          dir_q;
  logic [CW-1:0] bit_cnt;
  logic [N-1:0]  rx_word;

  // State register plus the datapath registers that move with it.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      hold    <= '0;
      dir_q   <= 1'b0;
      bit_cnt <= '0;
      rx_word <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (VALID) begin
            hold    <= DATA;
            dir_q   <= DIR_REQ;
            bit_cnt <= '0;
            rx_word <= '0;
          end
        end
        SHIFT: begin
          // Capture order mirrors the shift direction so the word comes back unchanged.
          if (dir_q) begin
            rx_word <= {rx_word[N-2:0], SER_IN};
          end else begin
            rx_word <= {SER_IN, rx_word[N-1:1]};
          end
          bit_cnt <= bit_cnt + CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Next state and decoded outputs; only FILL reaches an output combinationally.
  always_comb begin
    state_nxt = state;
    READY     = 1'b0;
    ENB       = 1'b0;
    MODO      = MODE_SHIFT;
    S_IN      = 1'b0;
    BUSY      = 1'b0;
    DONE      = 1'b0;
    case (state)
      IDLE: begin
        READY = 1'b1;
        if (VALID) begin
          state_nxt = LOAD;
        end
      end
      LOAD: begin
        ENB       = 1'b1;
        MODO      = MODE_LOAD;
        BUSY      = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        ENB  = 1'b1;
        S_IN = FILL;
        BUSY = 1'b1;
        // bit_cnt == N-1 means this edge takes the last sample.
        if (bit_cnt == LAST_BIT) begin
          state_nxt = FIN;
        end
      end
      FIN: begin
        DONE      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign D       = hold;
  assign DIR     = dir_q;
  assign BIT_CNT = bit_cnt;
  assign RX_WORD = rx_word;

endmodule

// File: tb/tb_ctrl_desp_32.sv
module tb_ctrl_desp_32;

  localparam int N  = 32;
  localparam int CW = 6;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          VALID = 1'b0;
  logic [N-1:0]  DATA = '0;
  logic          DIR_REQ = 1'b0;
  logic          FILL = 1'b0;
  logic          SER_IN;
  logic          READY, ENB, DIR, S_IN, BUSY, DONE;
  logic [1:0]    MODO;
  logic [N-1:0]  D, RX_WORD;
  logic [CW-1:0] BIT_CNT;

  int checks = 0;
  int failures = 0;

  ctrl_desp_32 #(.N(N), .CW(CW)) dut (
    .CLK(CLK), .RESET(RESET), .VALID(VALID), .DATA(DATA), .DIR_REQ(DIR_REQ),
    .FILL(FILL), .SER_IN(SER_IN), .READY(READY), .ENB(ENB), .DIR(DIR),
    .MODO(MODO), .D(D), .S_IN(S_IN), .BUSY(BUSY), .DONE(DONE),
    .BIT_CNT(BIT_CNT), .RX_WORD(RX_WORD)
  );

  always #5 CLK = ~CLK;

  // Behavioural universal shift register hanging off the DUT outputs.
  logic [N-1:0] sreg = '0;
  always @(posedge CLK) begin
    if (ENB) begin
      if (MODO == 2'b10) sreg <= D;
      else if (MODO == 2'b00) sreg <= DIR ? {sreg[N-2:0], S_IN} : {S_IN, sreg[N-1:1]};
    end
  end
  assign SER_IN = DIR ? sreg[N-1] : sreg[0];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // After k samples the received word holds the first k transmitted bits.
  function automatic logic [N-1:0] partial(input logic [N-1:0] w, input logic dir, input int k);
    if (k == 0) return '0;
    return dir ? (w >> (N - k)) : (w << (N - k));
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".ready"}, READY, 1);
    chk({tag, ".enb"}, ENB, 0);
    chk({tag, ".dir"}, DIR, 0);
    chk({tag, ".modo"}, MODO, 0);
    chk({tag, ".d"}, D, 0);
    chk({tag, ".s_in"}, S_IN, 0);
    chk({tag, ".busy"}, BUSY, 0);
    chk({tag, ".done"}, DONE, 0);
    chk({tag, ".bit_cnt"}, BIT_CNT, 0);
    chk({tag, ".rx_word"}, RX_WORD, 0);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic send_word(input logic [N-1:0] w, input logic dir, input logic fill,
                           input int pulse_at, input int abort_at);
    chk("pre.ready", READY, 1);
    VALID = 1'b1; DATA = w; DIR_REQ = dir; FILL = fill;
    @(negedge CLK);
    chk("load.enb", ENB, 1);
    chk("load.modo", MODO, 2'b10);
    chk("load.d", D, w);
    chk("load.dir", DIR, dir);
    chk("load.ready", READY, 0);
    chk("load.busy", BUSY, 1);
    chk("load.s_in", S_IN, 0);
    chk("load.done", DONE, 0);
    VALID = 1'b0; DATA = $urandom; DIR_REQ = ~dir;
    for (int j = 0; j < N; j++) begin
      @(negedge CLK);
      chk("shift.enb", ENB, 1);
      chk("shift.modo", MODO, 2'b00);
      chk("shift.s_in", S_IN, fill);
      chk("shift.dir", DIR, dir);
      chk("shift.ready", READY, 0);
      chk("shift.busy", BUSY, 1);
      chk("shift.done", DONE, 0);
      chk("shift.d", D, w);
      chk("shift.bit_cnt", BIT_CNT, j);
      chk("shift.rx_word", RX_WORD, partial(w, dir, j));
      VALID = (j == pulse_at);
      if (j == pulse_at) DATA = 32'h1234_5678;
      if (j == abort_at) begin
        RESET = 1'b1;
        @(negedge CLK);
        chk_reset_vals("abort");
        RESET = 1'b0;
        VALID = 1'b0;
        @(negedge CLK);
        chk("abort.done_after", DONE, 0);
        chk("abort.idle_enb", ENB, 0);
        chk("abort.idle_ready", READY, 1);
        return;
      end
    end
    @(negedge CLK);
    chk("fin.done", DONE, 1);
    chk("fin.enb", ENB, 0);
    chk("fin.busy", BUSY, 0);
    chk("fin.ready", READY, 0);
    chk("fin.modo", MODO, 0);
    chk("fin.s_in", S_IN, 0);
    chk("fin.bit_cnt", BIT_CNT, N);
    chk("fin.rx_word", RX_WORD, w);
    chk("fin.d", D, w);
    VALID = 1'b0;
    @(negedge CLK);
    chk("idle.ready", READY, 1);
    chk("idle.done", DONE, 0);
    chk("idle.enb", ENB, 0);
    chk("idle.rx_hold", RX_WORD, w);
    chk("idle.cnt_hold", BIT_CNT, N);
  endtask

  typedef struct {
    logic [N-1:0] data;
    logic         dir;
    logic         fill;
    logic [N-1:0] exp_rx;
  } vec_t;

  vec_t tbl[5];

  initial begin
    int load1, load2, done1, done2, ready1, n_load, n_done;
    logic [N-1:0] w2 [2];

    tbl[0] = '{32'hA5C3_0F1E, 1'b1, 1'b0, 32'hA5C3_0F1E};
    tbl[1] = '{32'h8000_0001, 1'b0, 1'b1, 32'h8000_0001};
    tbl[2] = '{32'hDEAD_BEEF, 1'b1, 1'b1, 32'hDEAD_BEEF};
    tbl[3] = '{32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000};
    tbl[4] = '{32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF};

    // Reset with a pending handshake: reset must win.
    RESET = 1'b1; VALID = 1'b1; DATA = 32'hFFFF_FFFF; DIR_REQ = 1'b1; FILL = 1'b1;
    @(negedge CLK);
    chk_reset_vals("reset1");
    @(negedge CLK);
    chk_reset_vals("reset2");
    RESET = 1'b0; VALID = 1'b0;
    @(negedge CLK);
    chk("post_reset.enb", ENB, 0);
    chk("post_reset.ready", READY, 1);

    // Table vectors.
    for (int i = 0; i < 5; i++) begin
      send_word(tbl[i].data, tbl[i].dir, tbl[i].fill, -1, -1);
      chk("tbl.rx_word", RX_WORD, tbl[i].exp_rx);
    end

    // Randomized words.
    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] w;
      w = $urandom;
      send_word(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, -1);
    end

    // VALID pulsed mid-shift is ignored.
    send_word(32'h0F0F_1234, 1'b1, 1'b0, 5, -1);

    // Abort at BIT_CNT=10, then a clean word.
    send_word(32'hCAFE_F00D, 1'b1, 1'b0, -1, 10);
    send_word(32'hDEAD_BEEF, 1'b0, 1'b0, -1, -1);

    // Back-to-back with VALID held high.
    w2[0] = 32'h1357_9BDF; w2[1] = 32'h2468_ACE0;
    load1 = -1; load2 = -1; done1 = -1; done2 = -1; ready1 = -1; n_load = 0; n_done = 0;
    VALID = 1'b1; DATA = w2[0]; DIR_REQ = 1'b1; FILL = 1'b0;
    for (int cyc = 1; cyc <= 90; cyc++) begin
      @(negedge CLK);
      if (ENB && MODO == 2'b10) begin
        if (n_load < 2) chk("b2b.load_d", D, w2[n_load]);
        if (n_load == 0) begin load1 = cyc; DATA = w2[1]; end
        else if (n_load == 1) begin load2 = cyc; VALID = 1'b0; end
        n_load++;
      end
      if (READY && load1 > 0 && ready1 < 0) ready1 = cyc;
      if (DONE) begin
        if (n_done < 2) chk("b2b.rx_word", RX_WORD, w2[n_done]);
        if (n_done == 0) done1 = cyc; else if (n_done == 1) done2 = cyc;
        n_done++;
      end
    end
    chk("b2b.n_load", n_load, 2);
    chk("b2b.n_done", n_done, 2);
    chk("b2b.first_latency", done1 - load1, N + 1);
    chk("b2b.ready_return", ready1 - done1, 1);
    chk("b2b.second_handshake", load2 - ready1, 1);
    chk("b2b.load_spacing", load2 - load1, N + 3);
    chk("b2b.done_spacing", done2 - done1, N + 3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
